// File: rtl/cam_pkg.sv
// Shared CAM definitions: default depth, index-width helper, scanner states.
package cam_pkg;

  localparam int CAM_DEPTH = 16;

  // A single-entry CAM still needs a one-bit index.
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } scan_state_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with any/at-most-one flags.
module cam_prio_enc #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [DEPTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any    = |vec;
  assign single = ~|(vec & (vec - DEPTH'(1)));

endmodule

// File: rtl/cam_match_scanner.sv
// Serialises a CAM match vector into per-entry index beats, lowest first.
// Define CAM_SCAN_COUNT_EN to add the registered hit_count output.
module cam_match_scanner
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] match_in,
  input  logic             match_valid,
  output logic             match_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_hit,
  output logic             idx_last,
  output logic             idx_valid,
  input  logic             idx_ready
`ifdef CAM_SCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   hit_count
`endif
);

  scan_state_t      state_q, state_d;
  logic [DEPTH-1:0] pending_q, pending_d;
  logic             rdy_en_q;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_single;
  logic             emit;
  logic             take;
  logic             accept;

  cam_prio_enc #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec    (pending_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  assign emit      = (state_q == EMIT);
  assign idx_valid = emit;
  assign idx_out   = emit ? enc_idx : '0;
  assign idx_hit   = emit & enc_any;
  assign idx_last  = emit & enc_single;

  assign take = emit & idx_ready;

  // Last beat taken frees the slot in the same cycle: no bubble.
  assign match_ready = rdy_en_q & (~emit | (enc_single & idx_ready));
  assign accept      = match_valid & match_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (take) begin
      pending_d = pending_q & (pending_q - DEPTH'(1));
      if (enc_single) state_d = IDLE;
    end
    if (accept) begin
      pending_d = match_in;
      state_d   = EMIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rdy_en_q  <= 1'b1;
    end
  end

`ifdef CAM_SCAN_COUNT_EN
  logic [IDX_W:0] hit_count_q, hit_count_d;

  always_comb begin
    hit_count_d = hit_count_q;
    if (accept) begin
      hit_count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        hit_count_d = hit_count_d + (IDX_W + 1)'(match_in[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_count_q <= '0;
    else        hit_count_q <= hit_count_d;
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_cam_match_scanner.sv
// Directed self-checking bench for cam_match_scanner.
module tb_cam_match_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] match_in;
  logic        match_valid;
  logic        match_ready;
  logic [3:0]  idx_out;
  logic        idx_hit;
  logic        idx_last;
  logic        idx_valid;
  logic        idx_ready;
`ifdef CAM_SCAN_COUNT_EN
  logic [4:0]  hit_count;
`endif

  int cmp  = 0;
  int errs = 0;

  logic [6:0] beat;
  assign beat = {idx_valid, idx_hit, idx_last, idx_out};

  always #5 clk = ~clk;

  cam_match_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .match_in    (match_in),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .idx_out     (idx_out),
    .idx_hit     (idx_hit),
    .idx_last    (idx_last),
    .idx_valid   (idx_valid),
    .idx_ready   (idx_ready)
`ifdef CAM_SCAN_COUNT_EN
    ,
    .hit_count   (hit_count)
`endif
  );

  function automatic logic [6:0] bt(input logic v, input logic h,
                                    input logic l, input logic [3:0] i);
    return {v, h, l, i};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    match_in = '0;
    match_valid = 1'b0;
    idx_ready = 1'b0;
    cyc();
    cyc();
    cmp++;
    if (beat !== 7'd0) begin
      errs++;
      $display("FAIL reset_beat: got %b want %b", beat, 7'd0);
    end
    cmp++;
    if (match_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready: got %b want 0", match_ready);
    end
`ifdef CAM_SCAN_COUNT_EN
    cmp++;
    if (hit_count !== 5'd0) begin
      errs++;
      $display("FAIL reset_count: got %0d want 0", hit_count);
    end
`endif
    rst_n = 1'b1;
    cyc();
    cmp++;
    if (match_ready !== 1'b1 || idx_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_reset: ready %b valid %b want 1 0",
               match_ready, idx_valid);
    end
  endtask

  task automatic test_miss();
    match_in = 16'h0000;
    match_valid = 1'b1;
    idx_ready = 1'b1;
    cyc();
    match_valid = 1'b0;
    #1;
    cmp++;
    if (beat !== bt(1, 0, 1, 0)) begin
      errs++;
      $display("FAIL miss_beat: got %b want %b", beat, bt(1, 0, 1, 0));
    end
`ifdef CAM_SCAN_COUNT_EN
    cmp++;
    if (hit_count !== 5'd0) begin
      errs++;
      $display("FAIL miss_count: got %0d want 0", hit_count);
    end
`endif
    cyc();
    cmp++;
    if (idx_valid !== 1'b0 || match_ready !== 1'b1) begin
      errs++;
      $display("FAIL miss_done: valid %b ready %b want 0 1",
               idx_valid, match_ready);
    end
  endtask

  task automatic test_multi();
    logic [3:0] exp_idx [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
    match_in = 16'h8421;
    match_valid = 1'b1;
    idx_ready = 1'b1;
    cyc();
    match_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      cmp++;
      if (beat !== bt(1, 1, k == 3, exp_idx[k])) begin
        errs++;
        $display("FAIL multi_beat%0d: got %b want %b", k, beat,
                 bt(1, 1, k == 3, exp_idx[k]));
      end
`ifdef CAM_SCAN_COUNT_EN
      cmp++;
      if (hit_count !== 5'd4) begin
        errs++;
        $display("FAIL multi_count%0d: got %0d want 4", k, hit_count);
      end
`endif
      cyc();
    end
    cmp++;
    if (idx_valid !== 1'b0) begin
      errs++;
      $display("FAIL multi_done: valid %b want 0", idx_valid);
    end
  endtask

  task automatic test_backpressure();
    match_in = 16'h0006;
    match_valid = 1'b1;
    idx_ready = 1'b0;
    cyc();
    match_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp++;
      if (beat !== bt(1, 1, 0, 1)) begin
        errs++;
        $display("FAIL hold%0d: got %b want %b", k, beat, bt(1, 1, 0, 1));
      end
      cyc();
    end
    idx_ready = 1'b1;
    #1;
    cmp++;
    if (beat !== bt(1, 1, 0, 1)) begin
      errs++;
      $display("FAIL bp_first: got %b want %b", beat, bt(1, 1, 0, 1));
    end
    cyc();
    cmp++;
    if (beat !== bt(1, 1, 1, 2)) begin
      errs++;
      $display("FAIL bp_second: got %b want %b", beat, bt(1, 1, 1, 2));
    end
    cyc();
    cmp++;
    if (idx_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_done: valid %b want 0", idx_valid);
    end
  endtask

  task automatic test_back_to_back();
    match_in = 16'h0001;
    match_valid = 1'b1;
    idx_ready = 1'b1;
    cyc();
    match_in = 16'h0100;
    #1;
    cmp++;
    if (beat !== bt(1, 1, 1, 0) || match_ready !== 1'b1) begin
      errs++;
      $display("FAIL b2b_first: got %b rdy %b want %b rdy 1",
               beat, match_ready, bt(1, 1, 1, 0));
    end
    cyc();
    match_valid = 1'b0;
    #1;
    cmp++;
    if (beat !== bt(1, 1, 1, 8)) begin
      errs++;
      $display("FAIL b2b_second: got %b want %b", beat, bt(1, 1, 1, 8));
    end
    cyc();
    cmp++;
    if (idx_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_done: valid %b want 0", idx_valid);
    end
  endtask

  task automatic test_reset_mid_emit();
    match_in = 16'hFFFF;
    match_valid = 1'b1;
    idx_ready = 1'b1;
    cyc();
    match_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp++;
      if (beat !== bt(1, 1, 0, 4'(k))) begin
        errs++;
        $display("FAIL ffff_beat%0d: got %b want %b", k, beat,
                 bt(1, 1, 0, 4'(k)));
      end
      cyc();
    end
    rst_n = 1'b0;
    #1;
    cmp++;
    if (beat !== 7'd0 || match_ready !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: got %b rdy %b want 0 rdy 0",
               beat, match_ready);
    end
`ifdef CAM_SCAN_COUNT_EN
    cmp++;
    if (hit_count !== 5'd0) begin
      errs++;
      $display("FAIL mid_reset_count: got %0d want 0", hit_count);
    end
`endif
    cyc();
    rst_n = 1'b1;
    cyc();
    cmp++;
    if (idx_valid !== 1'b0 || match_ready !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset_release: valid %b rdy %b want 0 1",
               idx_valid, match_ready);
    end
    match_in = 16'h0010;
    match_valid = 1'b1;
    cyc();
    match_valid = 1'b0;
    #1;
    cmp++;
    if (beat !== bt(1, 1, 1, 4)) begin
      errs++;
      $display("FAIL after_reset: got %b want %b", beat, bt(1, 1, 1, 4));
    end
    cyc();
  endtask

  task automatic test_ignore_busy();
    match_in = 16'h0003;
    match_valid = 1'b1;
    idx_ready = 1'b0;
    cyc();
    match_in = 16'h8000;
    #1;
    cmp++;
    if (match_ready !== 1'b0) begin
      errs++;
      $display("FAIL busy_ready: got %b want 0", match_ready);
    end
    cyc();
    match_valid = 1'b0;
    idx_ready = 1'b1;
    #1;
    cmp++;
    if (beat !== bt(1, 1, 0, 0)) begin
      errs++;
      $display("FAIL busy_beat0: got %b want %b", beat, bt(1, 1, 0, 0));
    end
    cyc();
    cmp++;
    if (beat !== bt(1, 1, 1, 1)) begin
      errs++;
      $display("FAIL busy_beat1: got %b want %b", beat, bt(1, 1, 1, 1));
    end
    cyc();
    cmp++;
    if (idx_valid !== 1'b0) begin
      errs++;
      $display("FAIL busy_done: valid %b want 0", idx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_multi();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();
    test_ignore_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
